// File: rtl/fmap_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fmap_reader: streams an H x W byte map from a 1-cycle-latency RAM onto a   |
// | valid/ready stream through a 2-entry skid FIFO.                  Rev 1.0   |
// +----------------------------------------------------------------------------+
module fmap_reader #(
  parameter int H         = 6,
  parameter int W         = 6,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        ram_data,
  output logic              ram_valid,
  input  logic              ram_ready
);

  localparam logic [15:0] c_total = 16'(H * W);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_rd_cnt;
  logic [15:0] r_tx_cnt;
  logic [1:0]  r_occ;
  logic        r_inflight;
  logic [7:0]  r_head;
  logic [7:0]  r_tail;
  logic        w_pop;
  logic        w_clear;
  logic [2:0]  w_outstanding;

  assign w_pop         = (r_occ != 2'd0) && ram_ready;
  // Bytes that will still occupy the FIFO after this cycle's pop; a new read
  // is only issued when it is guaranteed a free slot on return.
  assign w_outstanding = 3'(r_occ) + 3'(r_inflight) - 3'(w_pop);

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign mem_addr  = ADDR_W'(BASE_ADDR + 32'(r_rd_cnt));
  assign ram_data  = r_head;
  assign ram_valid = (r_occ != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_en      = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_READ;
          w_clear     = 1'b1;
        end
      end
      S_READ: begin
        mem_en = (r_rd_cnt < c_total) && (w_outstanding < 3'd2);
        if (r_rd_cnt == c_total) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_tx_cnt == c_total) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_cnt   <= 16'd0;
      r_tx_cnt   <= 16'd0;
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_head     <= 8'd0;
      r_tail     <= 8'd0;
    end else if (w_clear) begin
      r_rd_cnt   <= 16'd0;
      r_tx_cnt   <= 16'd0;
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_head     <= 8'd0;
      r_tail     <= 8'd0;
    end else begin
      r_inflight <= mem_en;
      if (mem_en) r_rd_cnt <= r_rd_cnt + 16'd1;
      if (w_pop)  r_tx_cnt <= r_tx_cnt + 16'd1;
      case ({r_inflight, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_head <= mem_rdata;
          else               r_tail <= mem_rdata;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_head <= r_tail;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_head <= mem_rdata;
          end else begin
            r_head <= r_tail;
            r_tail <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(r_inflight && (r_occ == 2'd2) && !w_pop));

endmodule
`default_nettype wire

// File: tb/tb_fmap_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fmap_reader: randomized self-checking bench for fmap_reader.            |
// |                                                                  Rev 1.0   |
// +----------------------------------------------------------------------------+
module tb_fmap_reader;

  localparam int TOTAL = 36;
  localparam int BASE_HI = 8'hF0;

  logic       clk = 1'b0;
  logic       rst, start, ram_ready;
  logic       busy, done, mem_en, ram_valid;
  logic [7:0] mem_addr, mem_rdata, ram_data;
  logic       start2, ready2;
  logic       busy2, done2, mem_en2, ram_valid2;
  logic [7:0] mem_addr2, mem_rdata2, ram_data2;
  logic [7:0] mem [256];

  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  bit   mon_en = 1'b0;
  bit   rand_ready = 1'b0;
  logic [7:0] addr_q[$];
  logic [7:0] data_q[$];

  fmap_reader #(.H(6), .W(6), .ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .ram_data(ram_data), .ram_valid(ram_valid), .ram_ready(ram_ready)
  );

  fmap_reader #(.H(6), .W(6), .ADDR_W(8), .BASE_ADDR(BASE_HI)) dut_hi (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .mem_en(mem_en2), .mem_addr(mem_addr2), .mem_rdata(mem_rdata2),
    .ram_data(ram_data2), .ram_valid(ram_valid2), .ram_ready(ready2)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with 1-cycle read latency, shared contents
  always @(posedge clk) begin
    if (mem_en)  mem_rdata  <= mem[mem_addr];
    if (mem_en2) mem_rdata2 <= mem[mem_addr2];
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) ram_ready = ($urandom_range(0, 99) < 30);
  end

  // Stream monitor: records reads/accepts, checks hold-under-stall and
  // that issued-minus-accepted never exceeds two.
  initial begin : monitor
    bit         prev_stall;
    logic [7:0] prev_data;
    int         outstanding;
    prev_stall = 1'b0;
    prev_data  = 8'd0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_stall = 1'b0;
      end else begin
        outstanding = addr_q.size() - data_q.size();
        checks++;
        if (outstanding > 2) begin
          failures++;
          $display("FAIL outstanding: got %0d, need <= 2", outstanding);
        end
        if (prev_stall) begin
          checks++;
          if (ram_valid !== 1'b1 || ram_data !== prev_data) begin
            failures++;
            $display("FAIL stall_hold: got valid=%b data=%02h, need valid=1 data=%02h",
                     ram_valid, ram_data, prev_data);
          end
        end
        prev_stall = ram_valid && !ram_ready;
        prev_data  = ram_data;
        if (mem_en) addr_q.push_back(mem_addr);
        if (ram_valid && ram_ready) data_q.push_back(ram_data);
        if (done) done_cnt++;
      end
    end
  end

  function automatic logic [7:0] exp_addr(int base, int k);
    return 8'((base + k) % 256);
  endfunction

  function automatic logic [7:0] exp_byte(int base, int k);
    return mem[(base + k) % 256];
  endfunction

  function automatic int first_bad(input logic [7:0] q[$], input int base);
    for (int k = 0; k < q.size(); k++)
      if (q[k] !== exp_byte(base, k)) return k;
    return -1;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic restart_monitor();
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    addr_q.delete();
    data_q.delete();
    done_cnt = 0;
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start2 = 1'b0; ram_ready = 1'b0; ready2 = 1'b1;
    #3;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL reset_ctrl: got busy=%b done=%b, need 0 0", busy, done);
    end
    checks++;
    if (mem_en !== 1'b0 || mem_addr !== 8'h00) begin
      failures++; $display("FAIL reset_mem: got en=%b addr=%02h, need 0 00", mem_en, mem_addr);
    end
    checks++;
    if (ram_valid !== 1'b0 || ram_data !== 8'h00) begin
      failures++; $display("FAIL reset_stream: got valid=%b data=%02h, need 0 00", ram_valid, ram_data);
    end
    checks++;
    if (mem_addr2 !== 8'hF0) begin
      failures++; $display("FAIL reset_base: got %02h, need F0", mem_addr2);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_full_rate();
    int n;
    bit seen;
    int bad;
    restart_monitor();
    ram_ready = 1'b1;
    pulse_start();
    @(negedge clk); n = 1;
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 8'h00 || busy !== 1'b1) begin
      failures++; $display("FAIL t1_first_read: got en=%b addr=%02h busy=%b, need 1 00 1", mem_en, mem_addr, busy);
    end
    @(negedge clk); n = 2;
    checks++;
    if (ram_valid !== 1'b0) begin
      failures++; $display("FAIL t1_valid_early: got %b, need 0", ram_valid);
    end
    @(negedge clk); n = 3;
    checks++;
    if (ram_valid !== 1'b1 || ram_data !== 8'h00) begin
      failures++; $display("FAIL t1_first_byte: got valid=%b data=%02h, need 1 00", ram_valid, ram_data);
    end
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk); n++;
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen || n != 40) begin
      failures++; $display("FAIL t1_done_time: got seen=%b cycle=%0d, need 1 40", seen, n);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || done_cnt != 1) begin
      failures++; $display("FAIL t1_after_done: got done=%b busy=%b pulses=%0d, need 0 0 1", done, busy, done_cnt);
    end
    checks++;
    if (addr_q.size() != TOTAL) begin
      failures++; $display("FAIL t1_read_count: got %0d, need %0d", addr_q.size(), TOTAL);
    end
    for (int k = 0; k < addr_q.size(); k++) begin
      checks++;
      if (addr_q[k] !== exp_addr(0, k)) begin
        failures++; $display("FAIL t1_addr[%0d]: got %02h, need %02h", k, addr_q[k], exp_addr(0, k));
      end
    end
    bad = first_bad(data_q, 0);
    checks++;
    if (data_q.size() != TOTAL || bad != -1) begin
      failures++; $display("FAIL t1_data: got count=%0d first_bad=%0d, need count=%0d first_bad=-1", data_q.size(), bad, TOTAL);
    end
  endtask

  task automatic test_random_ready();
    int n;
    bit seen;
    int bad;
    restart_monitor();
    rand_ready = 1'b1;
    pulse_start();
    n = 0; seen = 1'b0;
    while (!seen && n < 2000) begin
      @(negedge clk); n++;
      if (done) seen = 1'b1;
    end
    rand_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (!seen || done_cnt != 1) begin
      failures++; $display("FAIL t2_done: got seen=%b pulses=%0d, need 1 1", seen, done_cnt);
    end
    bad = first_bad(data_q, 0);
    checks++;
    if (data_q.size() != TOTAL || bad != -1) begin
      failures++; $display("FAIL t2_data: got count=%0d first_bad=%0d, need count=%0d first_bad=-1", data_q.size(), bad, TOTAL);
    end
  endtask

  task automatic test_backpressure();
    int n;
    bit seen;
    bit hold_ok;
    int bad;
    restart_monitor();
    ram_ready = 1'b0;
    pulse_start();
    hold_ok = 1'b1;
    for (n = 1; n <= 22; n++) begin
      @(negedge clk);
      if (n >= 3 && (ram_valid !== 1'b1 || ram_data !== 8'h00)) hold_ok = 1'b0;
    end
    checks++;
    if (!hold_ok) begin
      failures++; $display("FAIL t3_hold: got valid=%b data=%02h, need 1 00 throughout", ram_valid, ram_data);
    end
    checks++;
    if (addr_q.size() != 2 || addr_q[0] !== 8'h00 || addr_q[1] !== 8'h01) begin
      failures++; $display("FAIL t3_reads: got count=%0d, need 2 reads at 00,01", addr_q.size());
    end
    @(posedge clk); #1;
    ram_ready = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk); n++;
      if (done) seen = 1'b1;
    end
    bad = first_bad(data_q, 0);
    checks++;
    if (!seen || data_q.size() != TOTAL || bad != -1) begin
      failures++; $display("FAIL t3_resume: got done=%b count=%0d first_bad=%0d, need 1 %0d -1", seen, data_q.size(), bad, TOTAL);
    end
  endtask

  task automatic test_start_ignored();
    int n;
    bit seen;
    int bad;
    restart_monitor();
    ram_ready = 1'b1;
    pulse_start();
    n = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk); n++;
      start = (n == 10);
      if (done) begin
        seen = 1'b1;
        start = 1'b1;
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (!seen || busy !== 1'b0 || addr_q.size() != TOTAL || data_q.size() != TOTAL || done_cnt != 1) begin
      failures++; $display("FAIL t4_ignored: got busy=%b reads=%0d accepts=%0d pulses=%0d, need 0 %0d %0d 1",
                           busy, addr_q.size(), data_q.size(), done_cnt, TOTAL, TOTAL);
    end
    restart_monitor();
    pulse_start();
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 8'h00) begin
      failures++; $display("FAIL t4_restart_addr: got en=%b addr=%02h, need 1 00", mem_en, mem_addr);
    end
    n = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk); n++;
      if (done) seen = 1'b1;
    end
    bad = first_bad(data_q, 0);
    checks++;
    if (!seen || data_q.size() != TOTAL || bad != -1) begin
      failures++; $display("FAIL t4_restart_data: got done=%b count=%0d first_bad=%0d, need 1 %0d -1", seen, data_q.size(), bad, TOTAL);
    end
  endtask

  task automatic test_async_reset();
    int n;
    bit seen;
    int bad;
    restart_monitor();
    ram_ready = 1'b1;
    pulse_start();
    n = 0;
    while (data_q.size() < 10 && n < 100) begin
      @(negedge clk); n++;
    end
    #2;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (ram_valid !== 1'b0 || mem_en !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL t5_async: got valid=%b en=%b busy=%b, need 0 0 0", ram_valid, mem_en, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    restart_monitor();
    pulse_start();
    n = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk); n++;
      if (done) seen = 1'b1;
    end
    bad = first_bad(data_q, 0);
    checks++;
    if (!seen || data_q.size() != TOTAL || bad != -1) begin
      failures++; $display("FAIL t5_after_reset: got done=%b count=%0d first_bad=%0d, need 1 %0d -1", seen, data_q.size(), bad, TOTAL);
    end
  endtask

  task automatic test_addr_wrap();
    logic [7:0] aq[$];
    logic [7:0] dq[$];
    int n;
    bit seen;
    int bad;
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk); n++;
      if (mem_en2) aq.push_back(mem_addr2);
      if (ram_valid2 && ready2) dq.push_back(ram_data2);
      if (done2) seen = 1'b1;
    end
    checks++;
    if (!seen || aq.size() != TOTAL) begin
      failures++; $display("FAIL t6_reads: got done=%b count=%0d, need 1 %0d", seen, aq.size(), TOTAL);
    end
    for (int k = 0; k < aq.size(); k++) begin
      checks++;
      if (aq[k] !== exp_addr(BASE_HI, k)) begin
        failures++; $display("FAIL t6_addr[%0d]: got %02h, need %02h", k, aq[k], exp_addr(BASE_HI, k));
      end
    end
    bad = first_bad(dq, BASE_HI);
    checks++;
    if (dq.size() != TOTAL || bad != -1) begin
      failures++; $display("FAIL t6_data: got count=%0d first_bad=%0d, need count=%0d first_bad=-1", dq.size(), bad, TOTAL);
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'(a);
    test_reset();
    test_full_rate();
    test_random_ready();
    test_backpressure();
    test_start_ignored();
    test_async_reset();
    test_addr_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
